instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the main control decoder in the single-issue MIPS core.
//  - Holds the PC and requests instruction words from instruction memory over a req/ready handshake.
//  - Latches each word and presents it with opcode = instr[31:26] to the control decoder, qualified by instr_valid.
//  - Computes the next PC once execute retires the instruction: sequential, beq-taken, optionally j.

---
 rtl/instruction_fetch_unit_if.sv | 9 +
 rtl/instruction_fetch_unit.sv | 67 ++++++
 tb/tb_instruction_fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory request/ready fetch bus
interface instruction_fetch_unit_if #(parameter int ADDR_W = 32);
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_ready;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage, IDLE/FETCH/ISSUE FSM with beq next-pc; define JUMP_EN to add j targets
module instruction_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  instruction_fetch_unit_if.master imem,
  output logic [31:0] instr,
  output logic [5:0] opcode,
  output logic instr_valid,
  input  logic instr_ready,
  input  logic branch,
  input  logic zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state;
  logic [ADDR_W-1:0] offset, next_pc;
  assign opcode = instr[31:26];
  assign pc_plus4 = pc + ADDR_W'(4);
  assign offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign imem.imem_addr = pc;
  always_comb begin
    next_pc = (branch & zero) ? pc_plus4 + offset : pc_plus4;
`ifdef JUMP_EN
    if (opcode == 6'b000010) begin
      next_pc = pc_plus4;
      next_pc[27:0] = {instr[25:0], 2'b00};
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
      instr <= '0;
      instr_valid <= 1'b0;
      imem.imem_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: if (imem.imem_ready) begin
          instr <= imem.imem_rdata;
          instr_valid <= 1'b1;
          imem.imem_req <= 1'b0;
          state <= ISSUE;
        end
        ISSUE: if (instr_ready) begin
          pc <= {next_pc[ADDR_W-1:2], 2'b00};
          instr_valid <= 1'b0;
          imem.imem_req <= 1'b1;
          state <= FETCH;
        end
        default: begin
          state <= IDLE;
          imem.imem_req <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed fetch/retire vectors with a queue-based scoreboard
module tb_instruction_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0] opcode;
  logic instr_valid, instr_ready = 1'b0, branch = 1'b0, zero = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];
  logic prev_req = 1'b0, prev_valid = 1'b0;
  instruction_fetch_unit_if #(.ADDR_W(32)) imem();
  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch),
    .zero(zero), .pc(pc), .pc_plus4(pc_plus4)
  );
  always #5 clk = ~clk;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (imem.imem_req && !prev_req) begin
      if (exp_addr.size() == 0) chk(0, "unexpected_req", imem.imem_addr, 32'hx);
      else begin
        logic [31:0] e;
        e = exp_addr.pop_front();
        chk(imem.imem_addr === e, "fetch_addr", imem.imem_addr, e);
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr.size() == 0) chk(0, "unexpected_valid", instr, 32'hx);
      else begin
        logic [31:0] e;
        e = exp_instr.pop_front();
        chk(instr === e, "instr", instr, e);
        chk(opcode === e[31:26], "opcode", {26'b0, opcode}, {26'b0, e[31:26]});
      end
    end
    prev_req = imem.imem_req;
    prev_valid = instr_valid;
  end
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req) return;
      @(negedge clk);
    end
    chk(0, "req_timeout", 32'h0, 32'h1);
  endtask
  task automatic step(input logic [31:0] w, input int fs, input int is, input bit br, input bit z, input logic [31:0] nxt);
    logic [31:0] a0;
    wait_req();
    a0 = imem.imem_addr;
    repeat (fs) begin
      @(negedge clk);
      chk(imem.imem_addr === a0 && imem.imem_req === 1'b1, "stall_fetch", imem.imem_addr, a0);
      chk(instr_valid === 1'b0, "stall_fetch_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem.imem_ready = 1'b1;
    imem.imem_rdata = w;
    exp_instr.push_back(w);
    @(negedge clk);
    imem.imem_ready = 1'b0;
    imem.imem_rdata = $urandom;
    chk(instr_valid === 1'b1 && imem.imem_req === 1'b0, "ready_to_valid", {31'b0, instr_valid}, 32'h1);
    repeat (is) begin
      @(negedge clk);
      chk(instr === w && pc === a0 && instr_valid === 1'b1, "stall_issue", instr, w);
      chk(imem.imem_req === 1'b0, "stall_issue_req", {31'b0, imem.imem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    branch = br;
    zero = z;
    exp_addr.push_back(nxt);
    @(negedge clk);
    instr_ready = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    chk(instr_valid === 1'b0 && imem.imem_req === 1'b1, "retire_to_req", {31'b0, imem.imem_req}, 32'h1);
    chk(pc === nxt, "next_pc", pc, nxt);
  endtask
  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(imem.imem_req === 1'b0 && instr_valid === 1'b0, "reset_ctrl", {30'b0, imem.imem_req, instr_valid}, 32'h0);
    chk(pc === 32'h0 && instr === 32'h0, "reset_regs", pc | instr, 32'h0);
    exp_addr.push_back(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(imem.imem_req === 1'b1, "idle_to_fetch", {31'b0, imem.imem_req}, 32'h1);
    step(32'h8C010004, 0, 0, 0, 0, 32'h4);
    step(32'h00000000, 0, 0, 1, 1, 32'h8);
    step(32'h1000FFFF, 0, 0, 1, 1, 32'h8);
    step(32'h1000FFFF, 0, 0, 1, 0, 32'hC);
    step(32'h20420001, 5, 3, 0, 0, 32'h10);
    step(32'h1000FFFA, 0, 0, 1, 1, 32'hFFFFFFFC);
    step(32'h00000020, 0, 0, 0, 0, 32'h0);
    step(32'h1000003F, 0, 0, 1, 1, 32'h100);
`ifdef JUMP_EN
    step(32'h08000010, 0, 0, 0, 0, 32'h40);
`else
    step(32'h08000010, 0, 0, 0, 0, 32'h104);
`endif
    wait_req();
    exp_addr.push_back(32'h0);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'hDEADBEEF;
    rst_n = 1'b0;
    @(negedge clk);
    imem.imem_ready = 1'b0;
    rst_n = 1'b1;
    chk(imem.imem_req === 1'b0 && instr_valid === 1'b0, "reset_in_fetch", {30'b0, imem.imem_req, instr_valid}, 32'h0);
    chk(pc === 32'h0 && instr === 32'h0, "reset_in_fetch_regs", pc | instr, 32'h0);
    wait_req();
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h8C010004;
    exp_instr.push_back(32'h8C010004);
    @(negedge clk);
    imem.imem_ready = 1'b0;
    chk(instr_valid === 1'b1, "valid_before_reset", {31'b0, instr_valid}, 32'h1);
    rst_n = 1'b0;
    instr_ready = 1'b1;
    exp_addr.push_back(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b0;
    chk(instr_valid === 1'b0 && pc === 32'h0, "reset_in_issue", pc, 32'h0);
    wait_req();
    @(negedge clk);
    chk(exp_addr.size() == 0 && exp_instr.size() == 0, "scoreboard_drained",
        exp_addr.size() + exp_instr.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
